sevenseg_scan_ctrl: RTL and testbench

- Time-multiplexing scheduler for the 8-digit, common-anode seven-segment display.
- Shares the single cathode bus (CA) between eight digit requesters by sequencing the anode strobes (AN).
- Inserts a ghost-blanking interval at the start of each slot and applies per-digit enable and global brightness PWM.
- Double-buffers the digit values so software or upstream logic updates only at frame boundaries, with no tearing. Sits between the switch/PWM-value logic and the board pins.

---
 rtl/sevenseg_scan_ctrl_if.sv | 24 ++
 rtl/sevenseg_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Signal bundle between the digit/PWM source logic and the display scanner.
// The master side supplies digit data and brightness and sees the pin-level
// outputs; the slave side is the scanner itself.
interface sevenseg_scan_ctrl_if;
  logic [31:0] DIGITS;
  logic [7:0]  DP;
  logic [7:0]  DIG_EN;
  logic        LOAD;
  logic [3:0]  BRIGHT;
  logic [7:0]  CA;
  logic [7:0]  AN;
  logic [2:0]  SLOT;
  logic        FRAME_DONE;

  modport master (
    output DIGITS, DP, DIG_EN, LOAD, BRIGHT,
    input  CA, AN, SLOT, FRAME_DONE
  );

  modport slave (
    input  DIGITS, DP, DIG_EN, LOAD, BRIGHT,
    output CA, AN, SLOT, FRAME_DONE
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scanner for an 8-digit common-anode seven-segment display.
// Each digit owns a DWELL-cycle slot; the first BLANK cycles of every slot
// keep all anodes off to hide ghosting while the cathodes change. Digit data
// is double-buffered and only swapped in at the frame wrap.
module sevenseg_scan_ctrl #(
  parameter int DWELL = 10000,
  parameter int BLANK = 100,
  parameter int CW    = 14
) (
  input  logic                 CLK,
  input  logic                 RST,
  sevenseg_scan_ctrl_if.slave  bus
);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  localparam state_t SLOT_START = (BLANK == 0) ? ST_DRIVE : ST_BLANK;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     slot, slot_nxt;
  logic           slot_wrap, frame_wrap;

  logic [31:0]    act_digits, pend_digits;
  logic [7:0]     act_dp, pend_dp;
  logic [7:0]     act_en, pend_en;
  logic           pend_valid;

  logic           lit;
  logic [3:0]     nibble;
  logic [7:0]     ca_q, an_q;
  logic [2:0]     slot_q;
  logic           frame_done_q;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign slot_wrap  = (cnt == CW'(DWELL - 1));
  assign frame_wrap = slot_wrap && (slot == 3'd7);

  // Next slot counter, slot index and blank/drive phase.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cnt_nxt   = cnt + CW'(1);
    slot_nxt  = slot;
    state_nxt = state;
    if (slot_wrap) begin
      cnt_nxt   = '0;
      slot_nxt  = slot + 3'd1;
      state_nxt = SLOT_START;
    end else if (cnt_nxt == CW'(BLANK)) begin
      state_nxt = ST_DRIVE;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      cnt   <= '0;
      slot  <= 3'd0;
      state <= SLOT_START;
    end else begin
      cnt   <= cnt_nxt;
      slot  <= slot_nxt;
      state <= state_nxt;
    end
  end

  // Pending buffer data; only meaningful while pend_valid is set.
  always_ff @(posedge CLK) begin
    // NOTE: this storage is deliberately not reset; pend_valid gates its use,
    // so clearing the data would only add reset fan-out.
    if (bus.LOAD && !frame_wrap) begin
      pend_digits <= bus.DIGITS;
      pend_dp     <= bus.DP;
      pend_en     <= bus.DIG_EN;
    end
  end

  // Pending-valid flag and active buffer swap at the frame wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_valid <= 1'b0;
      act_digits <= '0;
      act_dp     <= '0;
      act_en     <= '0;
    end else if (frame_wrap) begin
      pend_valid <= 1'b0;
      if (bus.LOAD) begin
        act_digits <= bus.DIGITS;
        act_dp     <= bus.DP;
        act_en     <= bus.DIG_EN;
      end else if (pend_valid) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_en     <= pend_en;
      end
    end else if (bus.LOAD) begin
      pend_valid <= 1'b1;
    end
  end

  assign nibble = act_digits[{slot, 2'b00} +: 4];
  assign lit    = (state == ST_DRIVE) && act_en[slot] && (cnt[3:0] <= bus.BRIGHT);

  // Registered pin outputs, one cycle behind the counter state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      an_q         <= 8'hFF;
      ca_q         <= 8'hFF;
      slot_q       <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= lit ? ~(8'd1 << slot) : 8'hFF;
      ca_q         <= lit ? {~act_dp[slot], seg_decode(nibble)} : 8'hFF;
      slot_q       <= slot;
      frame_done_q <= frame_wrap;
    end
  end

  assign bus.AN         = an_q;
  assign bus.CA         = ca_q;
  assign bus.SLOT       = slot_q;
  assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl with DWELL=20, BLANK=4.
// The stimulus side predicts every output cycle and queues it; the monitor
// pops one entry per cycle and compares it with the pins.
module tb_sevenseg_scan_ctrl;
  localparam int DWELL = 20;
  localparam int BLANK = 4;
  localparam int CW    = 14;
  localparam int FRAME = 8 * DWELL;

  // Active-low {g..a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] ca;
    logic [2:0] slot;
    logic       fd;
  } out_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  sevenseg_scan_ctrl_if bus();

  sevenseg_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK), .CW(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Spec-level model state: cycles since reset and the two buffers.
  int          t = 0;
  logic [31:0] m_dig = '0, p_dig = '0;
  logic [7:0]  m_dp = '0, p_dp = '0;
  logic [7:0]  m_en = '0, p_en = '0;
  bit          p_valid = 1'b0;

  // Monitor: one comparison per output cycle, away from the active edge.
  initial begin
    out_t e, a;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{an: bus.AN, ca: bus.CA, slot: bus.SLOT, fd: bus.FRAME_DONE};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got an=%h ca=%h slot=%0d fd=%b, want an=%h ca=%h slot=%0d fd=%b",
                   $time, a.an, a.ca, a.slot, a.fd, e.an, e.ca, e.slot, e.fd);
        end
      end
    end
  end

  // Predict the output of the coming edge, clock once, then advance the model.
  task automatic step();
    out_t        e;
    int          c, s;
    bit          wrap, on, rst_s, load_s;
    logic [31:0] d_s;
    logic [7:0]  dp_s, en_s;
    logic [3:0]  nib;
    rst_s  = RST;
    load_s = bus.LOAD;
    d_s    = bus.DIGITS;
    dp_s   = bus.DP;
    en_s   = bus.DIG_EN;
    c      = t % DWELL;
    s      = (t / DWELL) % 8;
    wrap   = (s == 7) && (c == DWELL - 1);
    if (rst_s) begin
      e = '{an: 8'hFF, ca: 8'hFF, slot: 3'd0, fd: 1'b0};
    end else begin
      nib    = m_dig[s*4 +: 4];
      on     = (c >= BLANK) && m_en[s] && ((c % 16) <= int'(bus.BRIGHT));
      e.an   = on ? ~(8'd1 << s) : 8'hFF;
      e.ca   = on ? {~m_dp[s], SEG[nib]} : 8'hFF;
      e.slot = 3'(s);
      e.fd   = wrap;
    end
    sb.push_back(e);
    @(posedge CLK);
    if (rst_s) begin
      t = 0; m_dig = '0; m_dp = '0; m_en = '0; p_valid = 1'b0;
    end else begin
      if (wrap) begin
        if (load_s) begin
          m_dig = d_s; m_dp = dp_s; m_en = en_s;
        end else if (p_valid) begin
          m_dig = p_dig; m_dp = p_dp; m_en = p_en;
        end
        p_valid = 1'b0;
      end else if (load_s) begin
        p_dig = d_s; p_dp = dp_s; p_en = en_s; p_valid = 1'b1;
      end
      t++;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int pos);
    while ((t % FRAME) != pos) step();
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    bus.DIGITS = d;
    bus.DP     = dp;
    bus.DIG_EN = en;
    bus.LOAD   = 1'b1;
    step();
    bus.LOAD   = 1'b0;
  endtask

  initial begin
    bus.DIGITS = '0;
    bus.DP     = '0;
    bus.DIG_EN = '0;
    bus.LOAD   = 1'b0;
    bus.BRIGHT = 4'd15;

    // Reset, then two blank frames with FRAME_DONE and SLOT stepping.
    run(2);
    RST = 1'b0;
    run(2 * FRAME);

    // Counting digits, all enabled, full brightness; visible next frame.
    run(10);
    load(32'h7654_3210, 8'h00, 8'hFF);
    run_to(0);
    run(FRAME);

    // Only digits 0 and 2 enabled, DP on digit 2.
    load(32'h7654_3210, 8'h04, 8'b0000_0101);
    run_to(0);
    run(2 * FRAME);

    // Reduced brightness: 4/16 duty, then minimum brightness.
    load(32'h7654_3210, 8'h81, 8'hFF);
    run_to(0);
    bus.BRIGHT = 4'd3;
    run(FRAME);
    bus.BRIGHT = 4'd0;
    run(FRAME / 2);
    bus.BRIGHT = 4'd15;

    // Two loads mid-frame: last one wins, current frame untouched.
    run_to(50);
    load(32'hFFFF_FFFF, 8'h00, 8'hFF);
    run(30);
    load(32'hAAAA_AAAA, 8'h00, 8'hFF);
    run_to(0);
    run(FRAME);

    // Load on the frame wrap itself bypasses the pending buffer.
    run_to(FRAME - 1);
    load(32'hFEDC_BA98, 8'hA5, 8'hFF);
    run(FRAME);

    // Pending load followed by reset mid-slot 3: display must stay blank.
    run_to(20);
    load(32'h1111_1111, 8'h00, 8'hFF);
    run_to(70);
    RST = 1'b1;
    step();
    RST = 1'b0;
    run(2 * FRAME);

    // Recovery after reset needs a fresh load plus a frame wrap.
    load(32'h0123_4567, 8'h0F, 8'hFF);
    run_to(0);
    run(FRAME);

    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
